// File: rtl/reflet_uart_debug_bridge_pkg.sv
// Shared definitions for the UART debug bridge: protocol bytes, FSM
// state encoding and serial timing constants.
package reflet_uart_debug_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    localparam int TICKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_ACCESS,
        ST_SAMPLE,
        ST_RESP
    } state_e;

    // Clocks per sub-bit tick, never below one so the divider stays legal.
    function automatic int tick_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * TICKS_PER_BIT);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/reflet_uart_bridge_serial.sv
// Serial front end of the debug bridge: baud tick generator, 8N1 byte
// receiver with a one-cycle rx_valid_o pulse, and 8N1 byte transmitter
// started by tx_start_i and reporting completion with tx_done_o.
module reflet_uart_bridge_serial
    import reflet_uart_debug_bridge_pkg::*;
#(
    parameter int clk_freq = 1000000,
    parameter int baud     = 9600
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_done_o
);

    localparam int DIV = tick_div(clk_freq, baud);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt_q;
    logic          tick;
    logic          rx_meta_q, rx_sync_q;
    logic          rx_busy_q, rx_low_q, rx_valid_q;
    logic [1:0]    rx_tick_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          tx_q, tx_active_q, tx_wait_q, tx_done_q;
    logic [1:0]    tx_tick_q;
    logic [3:0]    tx_bits_q;
    logic [9:0]    tx_frame_q;

    assign tick       = (div_cnt_q == DW'(DIV - 1));
    assign tx_o       = tx_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_shift_q;
    assign tx_done_o  = tx_done_q;

    // Free-running divider producing one tick per quarter bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            div_cnt_q <= '0;
        else if (tick)
            div_cnt_q <= '0;
        else
            div_cnt_q <= div_cnt_q + 1'b1;
    end

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver: two consecutive low ticks confirm a start bit, then one
    // sample every four ticks; a low stop bit silently drops the byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_busy_q  <= 1'b0;
            rx_low_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if (tick) begin
                if (!rx_busy_q) begin
                    if (!rx_sync_q) begin
                        if (rx_low_q) begin
                            rx_busy_q <= 1'b1;
                            rx_low_q  <= 1'b0;
                            rx_tick_q <= '0;
                            rx_bit_q  <= '0;
                        end else begin
                            rx_low_q <= 1'b1;
                        end
                    end else begin
                        rx_low_q <= 1'b0;
                    end
                end else begin
                    rx_tick_q <= rx_tick_q + 2'd1;
                    if (rx_tick_q == 2'(TICKS_PER_BIT - 1)) begin
                        if (rx_bit_q == 4'd8) begin
                            rx_busy_q  <= 1'b0;
                            rx_valid_q <= rx_sync_q;
                        end else begin
                            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                            rx_bit_q   <= rx_bit_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Transmitter: a start request waits for the next tick, then shifts out
    // start, eight data bits LSB first and stop, four ticks each.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            tx_wait_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_tick_q   <= '0;
            tx_bits_q   <= '0;
            tx_frame_q  <= '1;
        end else begin
            tx_done_q <= 1'b0;
            if (tx_start_i) begin
                tx_frame_q  <= {1'b1, tx_data_i, 1'b0};
                tx_active_q <= 1'b1;
                tx_wait_q   <= 1'b1;
                tx_bits_q   <= 4'd10;
            end else if (tick && tx_active_q) begin
                if (tx_wait_q) begin
                    tx_wait_q <= 1'b0;
                    tx_q      <= tx_frame_q[0];
                    tx_tick_q <= '0;
                end else begin
                    tx_tick_q <= tx_tick_q + 2'd1;
                    if (tx_tick_q == 2'(TICKS_PER_BIT - 1)) begin
                        if (tx_bits_q == 4'd1) begin
                            tx_active_q <= 1'b0;
                            tx_done_q   <= 1'b1;
                            tx_q        <= 1'b1;
                        end else begin
                            tx_frame_q <= {1'b1, tx_frame_q[9:1]};
                            tx_q       <= tx_frame_q[1];
                            tx_bits_q  <= tx_bits_q - 4'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/reflet_uart_debug_bridge.sv
// UART-driven bus initiator. Host frames: 0x57 A.. D (write, ACK reply) and
// 0x52 A.. (read, data reply), address big-endian; anything else gets NAK.
// Optional inter-byte timeout in ADDR/DATA: REFLET_UART_BRIDGE_TIMEOUT_EN.
module reflet_uart_debug_bridge
    import reflet_uart_debug_bridge_pkg::*;
#(
    parameter int addr_size      = 16,
    parameter int clk_freq       = 1000000,
    parameter int baud           = 9600,
    parameter int timeout_cycles = 100000
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 rx_i,
    output logic                 tx_o,
    output logic                 bus_req_o,
    input  logic                 bus_grant_i,
    output logic                 enable_o,
    output logic [addr_size-1:0] addr_o,
    output logic                 write_en_o,
    output logic [7:0]           data_out_o,
    input  logic [7:0]           data_in_i,
    output logic                 busy_o
);

    localparam int         N_BYTES   = addr_size / 8;
    localparam logic [1:0] LAST_BYTE = 2'(N_BYTES - 1);

    state_e               state_q;
    logic                 is_write_q, bus_req_q, enable_q, write_en_q, busy_q;
    logic                 tx_start_q;
    logic [1:0]           byte_cnt_q;
    logic [addr_size-1:0] addr_q, addr_shift_d;
    logic [7:0]           data_out_q, tx_data_q, rx_byte;
    logic                 rx_valid, tx_done, timeout_hit;

    reflet_uart_bridge_serial #(
        .clk_freq (clk_freq),
        .baud     (baud)
    ) u_serial (
        .clk_i      (clk_i),
        .rst_ni     (reset_ni),
        .rx_i       (rx_i),
        .tx_o       (tx_o),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_byte),
        .tx_start_i (tx_start_q),
        .tx_data_i  (tx_data_q),
        .tx_done_o  (tx_done)
    );

    // Address bytes arrive MSB first, so each one shifts in from the right.
    generate
        if (addr_size > 8) begin : g_addr_wide
            assign addr_shift_d = {addr_q[addr_size-9:0], rx_byte};
        end else begin : g_addr_byte
            assign addr_shift_d = rx_byte;
        end
    endgenerate

`ifdef REFLET_UART_BRIDGE_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    // Inter-byte timer, running only while a frame is being collected.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            to_cnt_q <= '0;
        else if (rx_valid || !(state_q == ST_ADDR || state_q == ST_DATA))
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 32'd1;
    end

    assign timeout_hit = (to_cnt_q == 32'(timeout_cycles - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign timeout_hit    = 1'b0;
`endif

    assign bus_req_o  = bus_req_q;
    assign enable_o   = enable_q;
    assign addr_o     = addr_q;
    assign write_en_o = write_en_q;
    assign data_out_o = data_out_q;
    assign busy_o     = busy_q;

    // Bridge FSM with all bus and handshake outputs registered.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            bus_req_q  <= 1'b0;
            enable_q   <= 1'b0;
            write_en_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            data_out_q <= '0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        byte_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                            is_write_q <= (rx_byte == CMD_WRITE);
                            state_q    <= ST_ADDR;
                        end else begin
                            tx_data_q  <= RSP_NAK;
                            tx_start_q <= 1'b1;
                            state_q    <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_q     <= addr_shift_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            if (is_write_q) begin
                                state_q <= ST_DATA;
                            end else begin
                                state_q   <= ST_REQ;
                                bus_req_q <= 1'b1;
                            end
                        end
                    end else if (timeout_hit) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        data_out_q <= rx_byte;
                        state_q    <= ST_REQ;
                        bus_req_q  <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (bus_grant_i) begin
                        state_q    <= ST_ACCESS;
                        enable_q   <= 1'b1;
                        write_en_q <= is_write_q;
                    end
                end
                ST_ACCESS: begin
                    if (is_write_q) begin
                        enable_q   <= 1'b0;
                        write_en_q <= 1'b0;
                        bus_req_q  <= 1'b0;
                        tx_data_q  <= RSP_ACK;
                        tx_start_q <= 1'b1;
                        state_q    <= ST_RESP;
                    end else begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    enable_q   <= 1'b0;
                    bus_req_q  <= 1'b0;
                    tx_data_q  <= data_in_i;
                    tx_start_q <= 1'b1;
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    if (tx_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_uart_debug_bridge.sv
// Bench for reflet_uart_debug_bridge: table of host frames plus hand-written
// grant-stall, reset-abort and (with REFLET_UART_BRIDGE_TIMEOUT_EN) timeout
// sequences. Expected bus accesses and serial replies go into queues when a
// frame is driven and are checked by monitors as the DUT produces them.
module tb_reflet_uart_debug_bridge;

    localparam int BIT_CLKS = (1000000 / (9600 * 4)) * 4;

    typedef struct packed {
        logic [2:0]  nbytes;
        logic [31:0] frame;
        logic [7:0]  din;
        logic        acc;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  rsp;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n, rx, bus_grant;
    logic [7:0]  data_in;
    logic        tx, bus_req, enable, write_en, busy;
    logic [15:0] addr;
    logic [7:0]  data_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    acc_t        exp_acc_q[$];
    logic [7:0]  exp_rsp_q[$];
    vec_t        vecs[7];

    reflet_uart_debug_bridge #(
        .addr_size      (16),
        .clk_freq       (1000000),
        .baud           (9600),
        .timeout_cycles (2000)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .rx_i        (rx),
        .tx_o        (tx),
        .bus_req_o   (bus_req),
        .bus_grant_i (bus_grant),
        .enable_o    (enable),
        .addr_o      (addr),
        .write_en_o  (write_en),
        .data_out_o  (data_out),
        .data_in_i   (data_in),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #990000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tx"}, 32'(tx), 32'h1);
        check({tag, "_bus_req"}, 32'(bus_req), 32'h0);
        check({tag, "_enable"}, 32'(enable), 32'h0);
        check({tag, "_write_en"}, 32'(write_en), 32'h0);
        check({tag, "_addr"}, 32'(addr), 32'h0);
        check({tag, "_data_out"}, 32'(data_out), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(posedge clk);
        end
        rx = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_frame(input logic [2:0] nbytes, input logic [31:0] frame);
        for (int k = 0; k < int'(nbytes); k++)
            send_byte(frame[31 - 8 * k -: 8]);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 8000 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_rsp_q.size() == 0 && exp_acc_q.size() == 0)
                done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%0b rsp_pending=%0d acc_pending=%0d, expected idle with nothing pending",
                     name, busy, exp_rsp_q.size(), exp_acc_q.size());
            exp_rsp_q.delete();
            exp_acc_q.delete();
        end
    endtask

    // Bus monitor: captures each enable burst and checks it against the queue.
    always @(negedge clk) begin : bus_mon
        int   en_run;
        acc_t cap, e;
        if (!rst_n) begin
            en_run = 0;
        end else begin
            if (write_en && !enable) begin
                n_tests++; n_fail++;
                $display("FAIL we_outside_enable: write_en=1 enable=0, expected write_en=0");
            end
            if (enable) begin
                if (en_run == 0) cap = '{we: write_en, addr: addr, data: data_out};
                if (!bus_req) begin
                    n_tests++; n_fail++;
                    $display("FAIL req_during_enable: bus_req=0, expected 1");
                end
                en_run++;
            end else if (en_run != 0) begin
                $display("[TB] access we=%0b addr=0x%04h data=0x%02h cycles=%0d", cap.we, cap.addr, cap.data, en_run);
                n_tests++;
                if (exp_acc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_access: addr=0x%04h we=%0b, expected no access", cap.addr, cap.we);
                end else begin
                    e = exp_acc_q.pop_front();
                    if (cap.we !== e.we || cap.addr !== e.addr || (e.we && cap.data !== e.data) ||
                        en_run != (e.we ? 1 : 2)) begin
                        n_fail++;
                        $display("FAIL access: got we=%0b addr=0x%04h data=0x%02h cycles=%0d, expected we=%0b addr=0x%04h data=0x%02h cycles=%0d",
                                 cap.we, cap.addr, cap.data, en_run, e.we, e.addr, e.data, e.we ? 1 : 2);
                    end
                end
                check("req_drop", 32'(bus_req), 32'h0);
                en_run = 0;
            end
        end
    end

    // Serial monitor: decodes each reply byte and checks it against the queue.
    always begin : tx_mon
        logic [7:0] b;
        logic       start_ok, stop_ok;
        logic [7:0] e;
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
            repeat (BIT_CLKS / 2) @(negedge clk);
            start_ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CLKS) @(negedge clk);
                b[i] = tx;
            end
            repeat (BIT_CLKS) @(negedge clk);
            stop_ok = (tx === 1'b1);
            $display("[TB] reply 0x%02h", b);
            n_tests++;
            if (exp_rsp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_reply: got 0x%02h, expected no reply", b);
            end else begin
                e = exp_rsp_q.pop_front();
                if (b !== e || !start_ok || !stop_ok) begin
                    n_fail++;
                    $display("FAIL reply: got 0x%02h start_ok=%0b stop_ok=%0b, expected 0x%02h with framing",
                             b, start_ok, stop_ok, e);
                end
            end
        end
    end

    initial begin
        int   viol;
        bit   seen;
        rst_n     = 1'b1;
        rx        = 1'b1;
        bus_grant = 1'b1;
        data_in   = 8'h00;

        //                nb    frame          din    acc   we    addr      data   rsp
        vecs[0] = '{3'd4, 32'h571234A5, 8'h00, 1'b1, 1'b1, 16'h1234, 8'hA5, 8'h06};
        vecs[1] = '{3'd3, 32'h5200FF00, 8'h3C, 1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C};
        vecs[2] = '{3'd1, 32'h41000000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h15};
        vecs[3] = '{3'd4, 32'h57FF0000, 8'h00, 1'b1, 1'b1, 16'hFF00, 8'h00, 8'h06};
        vecs[4] = '{3'd3, 32'h52FFFF00, 8'hFF, 1'b1, 1'b0, 16'hFFFF, 8'h00, 8'hFF};
        vecs[5] = '{3'd1, 32'hFF000000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h15};
        vecs[6] = '{3'd3, 32'h52800100, 8'h00, 1'b1, 1'b0, 16'h8001, 8'h00, 8'h00};

        #3 rst_n = 1'b0;
        #2 check_reset_state("reset");
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);

        for (int v = 0; v < 7; v++) begin
            data_in = vecs[v].din;
            if (vecs[v].acc)
                exp_acc_q.push_back('{we: vecs[v].we, addr: vecs[v].addr, data: vecs[v].data});
            exp_rsp_q.push_back(vecs[v].rsp);
            send_frame(vecs[v].nbytes, vecs[v].frame);
            wait_idle($sformatf("vec%0d", v));
            check($sformatf("vec%0d_tx_idle", v), 32'(tx), 32'h1);
            $display("[TB] vector %0d frame 0x%08h done", v, vecs[v].frame);
        end

        // Grant stall: bus_req held, no enable, access one cycle after grant.
        bus_grant = 1'b0;
        exp_acc_q.push_back('{we: 1'b1, addr: 16'hABCD, data: 8'h5A});
        exp_rsp_q.push_back(8'h06);
        send_frame(3'd4, 32'h57ABCD5A);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = bus_req;
        end
        check("stall_req_seen", 32'(seen), 32'h1);
        viol = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!bus_req || enable) viol++;
        end
        check("stall_hold_violations", 32'(viol), 32'h0);
        @(posedge clk);
        #1 bus_grant = 1'b1;
        @(posedge clk);
        #1 check("grant_to_enable", 32'(enable), 32'h1);
        wait_idle("stall");
        $display("[TB] grant stall sequence done");

        // Reset in ADDR: aborted frame must leave no trace, next frame works.
        send_frame(3'd2, 32'h57120000);
        check("mid_addr_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #2 check_reset_state("midreset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (BIT_CLKS * 2) @(posedge clk);
        check("post_reset_busy", 32'(busy), 32'h0);
        exp_acc_q.push_back('{we: 1'b1, addr: 16'h0BEE, data: 8'h77});
        exp_rsp_q.push_back(8'h06);
        send_frame(3'd4, 32'h570BEE77);
        wait_idle("after_reset");
        $display("[TB] reset abort sequence done");

`ifdef REFLET_UART_BRIDGE_TIMEOUT_EN
        // Partial write times out silently; a following read is served.
        send_frame(3'd2, 32'h57120000);
        repeat (3000) @(posedge clk);
        @(negedge clk);
        check("timeout_busy", 32'(busy), 32'h0);
        data_in = 8'h99;
        exp_acc_q.push_back('{we: 1'b0, addr: 16'h0010, data: 8'h00});
        exp_rsp_q.push_back(8'h99);
        send_frame(3'd3, 32'h52001000);
        wait_idle("timeout_read");
        $display("[TB] timeout sequence done");
`endif

        repeat (20) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
